seq_alu: RTL and testbench

- Parametrised, registered successor of the 16-bit combinational ALU.
- Adds a valid/ready handshake on input and output, a registered result and flag register, and carry-chained ADDC/SUBB.
- Adds an iterative shift-add multiplier.
- Sits between the register-file read stage and writeback in the next-generation datapath; one operation in flight at a time.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/seq_alu_mul.sv | 63 ++++++
 rtl/seq_alu.sv | 172 +++++++++++++++++
 tb/tb_seq_alu.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents:
//   - opcode encodings driven on S_ALU
//   - bit positions inside the {S,Z,C,V} flag word
//   - FSM state encoding used by seq_alu
//   - pack_flags: assembles a flag word from its four bits
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_ADDC = 4'b0101;
  localparam logic [3:0] OP_SUBB = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SLR  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  localparam int F_S = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  // Flag word reported for an illegal opcode: only Z set.
  localparam logic [3:0] FLAGS_ILLEGAL = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [3:0] pack_flags(input logic s, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f      = '0;
    f[F_S] = s;
    f[F_Z] = z;
    f[F_C] = c;
    f[F_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier.
// Ports:
//   clk     - clock
//   clear   - synchronous abort, drops any multiply in progress
//   start   - load operands and begin (ignored while busy)
//   a, b    - WIDTH-bit unsigned operands
//   busy    - a multiply is loaded or iterating
//   done    - product is final this cycle (one-cycle pulse, busy also high)
//   product - 2*WIDTH-bit product, valid while done is high
// Timing: start edge loads, the next WIDTH edges each add one partial
// product, and done is asserted in the cycle after the last one.
module seq_alu_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  logic [CW-1:0]      cnt_p1;
  logic [2*WIDTH-1:0] mcand_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0]   mplier_p1;

  // Control: counter and busy are the only reset state.
  always_ff @(posedge clk) begin
    if (clear) begin
      busy   <= 1'b0;
      cnt_p1 <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt_p1 <= CNT_LOAD;
    end else if (busy) begin
      if (cnt_p1 != '0) cnt_p1 <= cnt_p1 - 1'b1;
      else              busy   <= 1'b0;
    end
  end

  // Datapath: one multiplier bit retired per cycle, LSB first.
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      mcand_p1  <= {{WIDTH{1'b0}}, a};
      mplier_p1 <= b;
      acc_p1    <= '0;
    end else if (busy && cnt_p1 != '0) begin
      if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  assign done    = busy && (cnt_p1 == '0);
  assign product = acc_p1;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, carry-chained ADDC/SUBB and
// an optional iterative multiplier. One operation is in flight at a time.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   IN_VALID, IN_READY  - operation handshake (fires when both high)
//   DATA_A, DATA_B      - operands; DATA_B low bits are the shift amount
//   S_ALU               - opcode
//   OUT_VALID, OUT_READY- result handshake
//   ALU_OUT             - registered result
//   FLAG_OUT            - registered flags {S,Z,C,V}
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  input  logic [3:0]       S_ALU,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [3:0]       FLAG_OUT
);

  localparam int MSB  = WIDTH - 1;
  localparam int SH_W = $clog2(WIDTH);

  state_t state_p1, state_nx;

  logic [WIDTH-1:0]   res_p1;
  logic [3:0]         flag_p1;

  logic               accept;
  logic               is_mul;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [SH_W-1:0]    shamt;
  logic [SH_W:0]      rot_amt;
  logic               cin;
  logic [WIDTH:0]     sum_c, dif_c, shl_c, srl_c;
  logic signed [WIDTH:0] sra_in, sra_c;
  logic [WIDTH-1:0]   res_c;
  logic [3:0]         flags_c;
  logic               c_c, v_c, illegal_c;

  assign accept = IN_VALID && IN_READY;
  assign is_mul = MUL_EN && (S_ALU == OP_MUL);

  // Single-cycle operations; everything is evaluated in WIDTH+1 bits so the
  // carry/borrow and the last bit shifted out fall into the extra bit.
  always_comb begin
    shamt     = DATA_B[SH_W-1:0];
    rot_amt   = (SH_W+1)'(WIDTH) - {1'b0, shamt};
    cin       = ((S_ALU == OP_ADDC) || (S_ALU == OP_SUBB)) ? flag_p1[F_C] : 1'b0;
    sum_c     = {1'b0, DATA_A} + {1'b0, DATA_B} + {{WIDTH{1'b0}}, cin};
    dif_c     = {1'b0, DATA_A} - {1'b0, DATA_B} - {{WIDTH{1'b0}}, cin};
    shl_c     = {1'b0, DATA_A} << shamt;
    srl_c     = {DATA_A, 1'b0} >> shamt;
    sra_in    = {DATA_A, 1'b0};
    sra_c     = sra_in >>> shamt;
    res_c     = '0;
    c_c       = 1'b0;
    v_c       = 1'b0;
    illegal_c = 1'b0;
    case (S_ALU)
      OP_ADD, OP_ADDC: begin
        res_c = sum_c[MSB:0];
        c_c   = sum_c[WIDTH];
        v_c   = (DATA_A[MSB] == DATA_B[MSB]) && (sum_c[MSB] != DATA_A[MSB]);
      end
      OP_SUB, OP_SUBB: begin
        res_c = dif_c[MSB:0];
        c_c   = dif_c[WIDTH];
        v_c   = (DATA_A[MSB] != DATA_B[MSB]) && (dif_c[MSB] != DATA_A[MSB]);
      end
      OP_AND: res_c = DATA_A & DATA_B;
      OP_OR:  res_c = DATA_A | DATA_B;
      OP_XOR: res_c = DATA_A ^ DATA_B;
      OP_SLL: begin
        res_c = shl_c[MSB:0];
        c_c   = shl_c[WIDTH];
      end
      // A right shift by WIDTH (shamt==0) yields zero, so n=0 rotates to A.
      OP_SLR: begin
        res_c = (DATA_A << shamt) | (DATA_A >> rot_amt);
        c_c   = shl_c[WIDTH];
      end
      OP_SRL: begin
        res_c = srl_c[WIDTH:1];
        c_c   = srl_c[0];
      end
      OP_SRA: begin
        res_c = sra_c[WIDTH:1];
        c_c   = sra_c[0];
      end
      // Real multiplies go to the iterative unit; this arm only sees MUL
      // when the multiplier is compiled out.
      OP_MUL:  illegal_c = !MUL_EN;
      default: illegal_c = 1'b1;
    endcase
    if (illegal_c) begin
      res_c   = '0;
      flags_c = FLAGS_ILLEGAL;
    end else begin
      flags_c = pack_flags(res_c[MSB], res_c == '0, c_c, v_c);
    end
  end

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .clear   (RST),
    .start   (accept && is_mul),
    .a       (DATA_A),
    .b       (DATA_B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // ---- stage p1: FSM state register ----
  always_ff @(posedge CLK) begin
    if (RST) state_p1 <= ST_IDLE;
    else     state_p1 <= state_nx;
  end

  always_comb begin
    state_nx = state_p1;
    case (state_p1)
      ST_IDLE: if (accept) state_nx = is_mul ? ST_MUL : ST_HOLD;
      ST_MUL: begin
        if (mul_done)      state_nx = ST_HOLD;
        else if (!mul_busy) state_nx = ST_IDLE;
      end
      ST_HOLD: begin
        if (accept)         state_nx = is_mul ? ST_MUL : ST_HOLD;
        else if (OUT_READY) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = !RST && ((state_p1 == ST_IDLE) ||
                         ((state_p1 == ST_HOLD) && OUT_READY));
    OUT_VALID = (state_p1 == ST_HOLD);
  end

  // ---- stage p1: result and flag register ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      res_p1  <= '0;
      flag_p1 <= '0;
    end else if (accept && !is_mul) begin
      res_p1  <= res_c;
      flag_p1 <= flags_c;
    end else if (mul_done) begin
      res_p1  <= mul_prod[MSB:0];
      flag_p1 <= pack_flags(mul_prod[MSB], mul_prod[MSB:0] == '0,
                            |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
    end
  end

  assign ALU_OUT  = res_p1;
  assign FLAG_OUT = flag_p1;

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu (WIDTH=16, MUL_EN=1).
module tb_seq_alu;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [15:0] DATA_A, DATA_B, ALU_OUT;
  logic [3:0]  S_ALU, FLAG_OUT;

  seq_alu #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA_A(DATA_A), .DATA_B(DATA_B), .S_ALU(S_ALU),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ALU_OUT(ALU_OUT), .FLAG_OUT(FLAG_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [15:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   pend_push;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge consume any offered result and note an
  // accept; resume #1 after the rising edge.
  task automatic cyc(output bit acc);
    exp_t e;
    @(negedge CLK);
    acc = IN_VALID && IN_READY;
    if (!RST && OUT_VALID && OUT_READY) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL spurious_result observed=%0h expected=none", ALU_OUT);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_r"}, ALU_OUT, e.r);
        chk({e.tag, "_f"}, FLAG_OUT, e.f);
      end
    end
    if (acc && pend_push) q.push_back(pend);
    @(posedge CLK);
    #1;
    if (acc) IN_VALID = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] r, input logic [3:0] f,
                       input bit push, output int waited);
    bit acc;
    acc       = 1'b0;
    pend      = '{tag, r, f};
    pend_push = push;
    S_ALU     = op;
    DATA_A    = a;
    DATA_B    = b;
    IN_VALID  = 1'b1;
    waited    = 0;
    while (!acc && waited < 60) begin
      cyc(acc);
      waited++;
    end
    if (!acc) begin
      total++;
      bad++;
      $error("FAIL accept_timeout_%s observed=%0d expected=accept", tag, waited);
      IN_VALID = 1'b0;
    end
  endtask

  initial begin
    int          w, lat;
    bit          d;
    logic [15:0] held_r;
    logic [3:0]  held_f;

    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    DATA_A = '0; DATA_B = '0; S_ALU = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_alu_out",   ALU_OUT,   0);
    chk("rst_flags",     FLAG_OUT,  0);
    chk("rst_in_ready",  IN_READY,  0);
    RST = 1'b0;
    #1;
    chk("post_rst_in_ready", IN_READY, 1);

    // Carry chain, borrow chain, overflow and shift boundaries.
    issue("add_wrap",  OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1, w);
    issue("addc",      OP_ADDC, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1, w);
    issue("add_ovf",   OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1, w);
    issue("sub_brw",   OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1, w);
    issue("subb",      OP_SUBB, 16'h0005, 16'h0002, 16'h0002, 4'b0000, 1, w);
    issue("sub_ovf",   OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1, w);
    issue("slr1",      OP_SLR,  16'h8001, 16'h0001, 16'h0003, 4'b0010, 1, w);
    issue("sra15",     OP_SRA,  16'h8000, 16'h000F, 16'hFFFF, 4'b1000, 1, w);
    issue("srl0",      OP_SRL,  16'h0001, 16'h0000, 16'h0001, 4'b0000, 1, w);
    repeat (3) cyc(d);

    // Multiply latency and backpressure.
    OUT_READY = 1'b0;
    issue("mul_big", OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 1, w);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK);
      #1;
      if (OUT_VALID) begin
        lat = k;
        break;
      end
    end
    chk("mul_latency", lat, 17);
    held_r = ALU_OUT;
    held_f = FLAG_OUT;
    chk("mul_big_r_held", held_r, 16'h0000);
    chk("mul_big_f_held", held_f, 4'b0110);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("bp_out_valid", OUT_VALID, 1);
      chk("bp_in_ready",  IN_READY,  0);
      chk("bp_alu_out",   ALU_OUT,   held_r);
      chk("bp_flags",     FLAG_OUT,  held_f);
    end
    OUT_READY = 1'b1;
    cyc(d);
    issue("mul_small", OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1, w);
    repeat (20) cyc(d);

    // Reset in the middle of a multiply aborts it.
    issue("pre_abort", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1, w);
    repeat (2) cyc(d);
    issue("abort_mul", OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 0, w);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_alu_out",   ALU_OUT,   0);
    chk("abort_flags",     FLAG_OUT,  0);
    chk("abort_out_valid", OUT_VALID, 0);
    chk("abort_in_ready",  IN_READY,  0);
    RST = 1'b0;
    #1;
    chk("abort_post_in_ready", IN_READY, 1);
    repeat (25) cyc(d);
    chk("abort_no_result", OUT_VALID, 0);

    // Back-to-back stream, one accept per cycle.
    issue("s_and", OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1, w);
    chk("s_and_wait", w, 1);
    issue("s_or",  OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1, w);
    chk("s_or_wait", w, 1);
    issue("s_xor", OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100, 1, w);
    chk("s_xor_wait", w, 1);
    issue("s_ill", 4'b0111, 16'h1234, 16'h5678, 16'h0000, 4'b0100, 1, w);
    chk("s_ill_wait", w, 1);
    issue("s_sll", OP_SLL, 16'h0001, 16'h000F, 16'h8000, 4'b1000, 1, w);
    chk("s_sll_wait", w, 1);
    issue("s_srl", OP_SRL, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 1, w);
    chk("s_srl_wait", w, 1);
    issue("s_add", OP_ADD, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 1, w);
    chk("s_add_wait", w, 1);
    issue("s_sub", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1, w);
    chk("s_sub_wait", w, 1);
    repeat (3) cyc(d);

    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
